pwm_capture: RTL and testbench

PWM_CAPTURE -- requirements
Module: pwm_capture

---
 rtl/pwm_capture_pkg.sv | 13 +
 rtl/sync2.sv | 22 ++
 rtl/pwm_capture.sv | 124 ++++++++++++
 tb/tb_pwm_capture.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/pwm_capture_pkg.sv
// Shared TapTempo constants and small helpers used by the capture block
// and the PWM generator.
package pwm_capture_pkg;

  // Default maximum BPM value; a PWM period is TT_BPM_MAX+1 timepulses long.
  localparam int TT_BPM_MAX = 250;

  // A falling edge between two consecutive timepulse samples.
  function automatic logic falling_edge(input logic prev, input logic cur);
    return prev & ~cur;
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer bringing an asynchronous level into the clk_i domain.
module sync2 (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops give the first stage a full cycle to settle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pwm_capture.sv
// Decodes a BPM value from a PWM waveform sampled once per timepulse.
// A window is BPM_MAX+1 samples starting at a falling edge; k high samples
// in a window decode to k-1. Without lock, a full window of highs decodes
// to BPM_MAX.
module pwm_capture
  import pwm_capture_pkg::*;
#(
  parameter int BPM_MAX = TT_BPM_MAX,
  localparam int W  = $clog2(BPM_MAX + 1),
  localparam int HW = $clog2(BPM_MAX + 2)
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         tp_i,
  input  logic         pwm_i,
  output logic [W-1:0] bpm_o,
  output logic         bpm_valid_o,
  output logic         lock_o,
  output logic         err_o
);

  typedef enum logic {HUNT, MEASURE} state_e;

  state_e        state, state_n;
  logic [W-1:0]  idx, idx_n;
  logic [HW-1:0] high_cnt, high_cnt_n;
  logic [HW-1:0] run_cnt, run_cnt_n;
  logic [HW-1:0] total;
  logic [W-1:0]  bpm_n;
  logic          valid_n, err_n;
  logic          s, prev, fall;

  sync2 u_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d     (pwm_i),
    .q     (s)
  );

  assign fall   = falling_edge(prev, s);
  assign total  = high_cnt + HW'(s);
  assign lock_o = (state == MEASURE);

  // Previous sample, refreshed on every timepulse in either state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) prev <= 1'b0;
    else if (tp_i) prev <= s;
  end

  // State and result registers; pulses come out one clock after the timepulse.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= HUNT;
      idx         <= '0;
      high_cnt    <= '0;
      run_cnt     <= '0;
      bpm_o       <= '0;
      bpm_valid_o <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      state       <= state_n;
      idx         <= idx_n;
      high_cnt    <= high_cnt_n;
      run_cnt     <= run_cnt_n;
      bpm_o       <= bpm_n;
      bpm_valid_o <= valid_n;
      err_o       <= err_n;
    end
  end

  // Next-state logic; idx holds the window index of the next sample.
  always_comb begin
    state_n    = state;
    idx_n      = idx;
    high_cnt_n = high_cnt;
    run_cnt_n  = run_cnt;
    bpm_n      = bpm_o;
    valid_n    = 1'b0;
    err_n      = 1'b0;
    if (tp_i) begin
      case (state)
        HUNT: begin
          if (fall) begin
            state_n    = MEASURE;
            idx_n      = W'(1);
            high_cnt_n = '0;
            run_cnt_n  = '0;
          end else if (!s) begin
            run_cnt_n = '0;
          end else if (run_cnt == HW'(BPM_MAX)) begin
            bpm_n     = W'(BPM_MAX);
            valid_n   = 1'b1;
            run_cnt_n = '0;
          end else begin
            run_cnt_n = run_cnt + HW'(1);
          end
        end
        MEASURE: begin
          if (fall && idx != '0) begin
            err_n      = 1'b1;
            idx_n      = W'(1);
            high_cnt_n = '0;
          end else if (idx == W'(BPM_MAX)) begin
            idx_n      = '0;
            high_cnt_n = '0;
            if (total != '0) begin
              bpm_n   = W'(total - HW'(1));
              valid_n = 1'b1;
            end else begin
              err_n     = 1'b1;
              state_n   = HUNT;
              run_cnt_n = '0;
            end
          end else begin
            high_cnt_n = total;
            idx_n      = idx + W'(1);
          end
        end
        default: state_n = HUNT;
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Self-checking bench for pwm_capture with BPM_MAX=20 and a result scoreboard.
module tb_pwm_capture;

  localparam int BPM_MAX = 20;
  localparam int W = $clog2(BPM_MAX + 1);

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic         tp_i = 1'b0;
  logic         pwm_i = 1'b0;
  logic [W-1:0] bpm_o;
  logic         bpm_valid_o, lock_o, err_o;

  typedef struct {
    int kind;
    int bpm;
    int tp;
  } exp_t;

  exp_t exp_q[$];
  int   check_count = 0;
  int   fail_count = 0;
  int   tp_count = 0;
  int   cycle = 0;
  int   last_tp_cycle = 0;

  pwm_capture #(.BPM_MAX(BPM_MAX)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .tp_i        (tp_i),
    .pwm_i       (pwm_i),
    .bpm_o       (bpm_o),
    .bpm_valid_o (bpm_valid_o),
    .lock_o      (lock_o),
    .err_o       (err_o)
  );

  // Free-running clock.
  always #5 clk_i = ~clk_i;

  // Cycle counter used to measure output latency.
  always @(posedge clk_i) cycle <= cycle + 1;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    check_count++;
    if (observed != expected) begin
      fail_count++;
      $display("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Drive one sample; kind 1 expects a valid, kind 2 an error on this timepulse.
  task automatic applyStimulus(input logic v, input int kind, input int val);
    exp_t e;
    if (kind != 0) begin
      e.kind = kind;
      e.bpm  = val;
      e.tp   = tp_count + 1;
      exp_q.push_back(e);
    end
    @(negedge clk_i);
    pwm_i = v;
    repeat (3) @(negedge clk_i);
    tp_i = 1'b1;
    tp_count++;
    last_tp_cycle = cycle;
    @(negedge clk_i);
    tp_i = 1'b0;
  endtask

  // One generator period for threshold k: low samples first, then k+1 highs.
  task automatic genPeriod(input int k, input bit expect_valid);
    for (int i = 0; i <= BPM_MAX; i++)
      applyStimulus(i >= BPM_MAX - k, (expect_valid && i == BPM_MAX) ? 1 : 0, k);
  endtask

  // Pops the scoreboard whenever the DUT reports a result or an error.
  always @(negedge clk_i) begin
    exp_t e;
    int   obs_kind;
    if (!rst_i && (bpm_valid_o || err_o)) begin
      obs_kind = bpm_valid_o ? 1 : 2;
      checkOutput("valid_err_exclusive", int'(bpm_valid_o & err_o), 0);
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_event", obs_kind, 0);
      end else begin
        e = exp_q.pop_front();
        checkOutput("event_kind", obs_kind, e.kind);
        checkOutput("event_bpm", int'(bpm_o), e.bpm);
        checkOutput("event_tp", tp_count, e.tp);
        checkOutput("event_latency", cycle - last_tp_cycle, 1);
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk_i);
    checkOutput("reset_bpm", int'(bpm_o), 0);
    checkOutput("reset_valid", int'(bpm_valid_o), 0);
    checkOutput("reset_lock", int'(lock_o), 0);
    checkOutput("reset_err", int'(err_o), 0);
    rst_i = 1'b0;

    // All-high run while unlocked decodes to the maximum.
    for (int i = 0; i <= BPM_MAX; i++) applyStimulus(1'b1, (i == BPM_MAX) ? 1 : 0, BPM_MAX);
    checkOutput("hunt_lock", int'(lock_o), 0);
    checkOutput("hunt_bpm", int'(bpm_o), BPM_MAX);

    // Falling edge locks; 15 low + 6 high windows decode to 5.
    applyStimulus(1'b0, 0, 0);
    checkOutput("lock_after_edge", int'(lock_o), 1);
    for (int i = 1; i <= BPM_MAX; i++) applyStimulus(i >= 15, (i == BPM_MAX) ? 1 : 0, 5);
    for (int n = 0; n < 2; n++)
      for (int i = 0; i <= BPM_MAX; i++) applyStimulus(i >= 15, (i == BPM_MAX) ? 1 : 0, 5);
    checkOutput("locked_lock", int'(lock_o), 1);

    // Misaligned falling edge at w=7, then a clean window from there.
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 0, 0);
    applyStimulus(1'b1, 0, 0);
    applyStimulus(1'b0, 2, 5);
    checkOutput("misalign_lock", int'(lock_o), 1);
    for (int i = 1; i <= BPM_MAX; i++) applyStimulus(i >= 15, (i == BPM_MAX) ? 1 : 0, 5);

    // Empty window drops lock and keeps the last value.
    for (int i = 0; i <= BPM_MAX; i++) applyStimulus(1'b0, (i == BPM_MAX) ? 2 : 0, 5);
    checkOutput("empty_lock", int'(lock_o), 0);
    checkOutput("empty_bpm", int'(bpm_o), 5);

    // Reset mid-window.
    applyStimulus(1'b1, 0, 0);
    applyStimulus(1'b0, 0, 0);
    checkOutput("relock", int'(lock_o), 1);
    for (int i = 1; i < 10; i++) applyStimulus(1'b1, 0, 0);
    @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    checkOutput("midrst_bpm", int'(bpm_o), 0);
    checkOutput("midrst_lock", int'(lock_o), 0);
    checkOutput("midrst_valid", int'(bpm_valid_o), 0);
    checkOutput("midrst_err", int'(err_o), 0);
    applyStimulus(1'b1, 0, 0);
    applyStimulus(1'b0, 0, 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 0, 0);
    checkOutput("post_rst_lock", int'(lock_o), 0);
    checkOutput("post_rst_bpm", int'(bpm_o), 0);

    // Generator loopback: 10 then 15.
    genPeriod(10, 1'b0);
    genPeriod(10, 1'b1);
    genPeriod(10, 1'b1);
    genPeriod(15, 1'b1);
    genPeriod(15, 1'b1);
    checkOutput("loop_lock", int'(lock_o), 1);
    checkOutput("loop_bpm", int'(bpm_o), 15);

    repeat (6) @(negedge clk_i);
    checkOutput("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
    $finish;
  end

endmodule
